// File: rtl/board_io_pkg.sv
// Shared types and 50 MHz timing defaults for the board input conditioning path.
package board_io_pkg;

  typedef enum logic [1:0] {
    REL,
    CHK_P,
    HELD,
    CHK_R
  } deb_state_e;

  localparam int DEB_10MS = 500000;
  localparam int LONG_1S  = 50000000;

endpackage

// File: rtl/debounce_ch.sv
// One input channel: synchroniser, polarity normalisation, debounce FSM and
// press/release/long-press pulse generation.
module debounce_ch
  import board_io_pkg::*;
#(
  parameter logic ACTIVE_LOW        = 1'b1,
  parameter int   SYNC_STAGES       = 2,
  parameter int   DEBOUNCE_CYCLES   = DEB_10MS,
  parameter int   LONG_PRESS_CYCLES = LONG_1S,
  parameter int   CNT_W             = $clog2(LONG_PRESS_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_evt,
  output logic release_evt,
  output logic long_evt
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_PRESS_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   fired_q, fired_d;
  logic                   press_d, release_d, long_d;

  // Reset loads the inactive pin level so no spurious edge appears at release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s       = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign cnt_inc = cnt_q + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REL;
      cnt_q       <= '0;
      fired_q     <= 1'b0;
      press_evt   <= 1'b0;
      release_evt <= 1'b0;
      long_evt    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fired_q     <= fired_d;
      press_evt   <= press_d;
      release_evt <= release_d;
      long_evt    <= long_d;
    end
  end

  // The single counter measures debounce time in CHK_P/CHK_R and hold time in HELD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fired_d = fired_q;
    unique case (state_q)
      REL: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            state_d = CHK_P;
            cnt_d   = ONE;
          end
        end
      end
      CHK_P: begin
        if (!s) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB_C) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = REL;
            cnt_d   = '0;
            fired_d = 1'b0;
          end else begin
            state_d = CHK_R;
            cnt_d   = ONE;
          end
        end else if (cnt_q < LONG_C) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LONG_C) fired_d = 1'b1;
        end
      end
      CHK_R: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= DEB_C) begin
          state_d = REL;
          cnt_d   = '0;
          fired_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level     = (state_q == HELD) || (state_q == CHK_R);
    press_d   = !level && (state_d == HELD);
    release_d = level && (state_d == REL);
    long_d    = (state_q == HELD) && s && (cnt_q < LONG_C) && (cnt_inc == LONG_C) && !fired_q;
  end

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions board KEY/SW pins per channel and merges their events into one
// latched, maskable interrupt with write-1-to-clear pending bits.
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int                NUM_CH            = 4,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK   = {NUM_CH{1'b1}},
  parameter int                SYNC_STAGES       = 2,
  parameter int                DEBOUNCE_CYCLES   = DEB_10MS,
  parameter int                LONG_PRESS_CYCLES = LONG_1S,
  parameter int                CNT_W             = $clog2(LONG_PRESS_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] release_o,
  output logic [NUM_CH-1:0] long_o,
  input  logic [NUM_CH-1:0] irq_en_i,
  output logic [NUM_CH-1:0] pend_o,
  input  logic [NUM_CH-1:0] pend_clr_i,
  output logic              irq_o
);

  logic [NUM_CH-1:0] pend_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .ACTIVE_LOW        (ACTIVE_LOW_MASK[i]),
      .SYNC_STAGES       (SYNC_STAGES),
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .CNT_W             (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw         (raw_in[i]),
      .level       (level_o[i]),
      .press_evt   (press_o[i]),
      .release_evt (release_o[i]),
      .long_evt    (long_o[i])
    );
  end

  // Events show in pend_o in the same cycle as their pulse; a simultaneous clear loses.
  assign pend_o = pend_q | press_o | long_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      irq_o  <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~pend_clr_i) | press_o | long_o;
      irq_o  <= |(pend_o & irq_en_i);
    end
  end

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed plus randomized bench for board_input_conditioner against a
// run-length behavioural model of the debounce/long-press/pending rules.
module tb_board_input_conditioner;

  localparam int         NCH   = 4;
  localparam int         SYNC  = 2;
  localparam int         DEB   = 8;
  localparam int         LONGC = 40;
  localparam logic [3:0] MASK  = 4'b0011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] raw_in, irq_en_i, pend_clr_i;
  logic [3:0] level_o, press_o, release_o, long_o, pend_o;
  logic       irq_o;

  int compared = 0;
  int mismatched = 0;

  logic [3:0] asserted;
  logic [3:0] pipe [$];
  int         run [NCH];
  int         age [NCH];
  bit         lvl [NCH];
  bit         fired [NCH];
  logic [3:0] exp_level, exp_press, exp_rel, exp_long, exp_pend_q, exp_pend;
  logic       exp_irq;

  board_input_conditioner #(
    .NUM_CH            (NCH),
    .ACTIVE_LOW_MASK   (MASK),
    .SYNC_STAGES       (SYNC),
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONGC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw_in),
    .level_o    (level_o),
    .press_o    (press_o),
    .release_o  (release_o),
    .long_o     (long_o),
    .irq_en_i   (irq_en_i),
    .pend_o     (pend_o),
    .pend_clr_i (pend_clr_i),
    .irq_o      (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chkInt(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic modelReset();
    pipe.delete();
    for (int k = 0; k < SYNC; k++) pipe.push_back(4'b0000);
    for (int i = 0; i < NCH; i++) begin
      run[i] = 0; age[i] = 0; lvl[i] = 0; fired[i] = 0;
    end
    exp_level = '0; exp_press = '0; exp_rel = '0; exp_long = '0;
    exp_pend_q = '0; exp_pend = '0; exp_irq = 1'b0;
  endtask

  // Advances the model by one clock edge using the inputs present at that edge.
  task automatic modelStep();
    logic [3:0] s;
    if (!rst_n) begin
      modelReset();
      return;
    end
    exp_irq    = |(exp_pend & irq_en_i);
    exp_pend_q = (exp_pend_q & ~pend_clr_i) | exp_press | exp_long;
    s = pipe.pop_front();
    pipe.push_back(asserted);
    exp_press = '0; exp_rel = '0; exp_long = '0;
    for (int i = 0; i < NCH; i++) begin
      if (s[i] != lvl[i]) begin
        run[i]++;
        if (run[i] == DEB) begin
          run[i] = 0;
          lvl[i] = ~lvl[i];
          if (lvl[i]) begin
            exp_press[i] = 1'b1;
            age[i] = 0;
          end else begin
            exp_rel[i] = 1'b1;
            fired[i] = 0;
          end
        end
      end else if (lvl[i] && run[i] > 0) begin
        run[i] = 0;
        age[i] = 0;
      end else begin
        run[i] = 0;
        if (lvl[i] && age[i] < LONGC) begin
          age[i]++;
          if (age[i] == LONGC && !fired[i]) begin
            exp_long[i] = 1'b1;
            fired[i] = 1;
          end
        end
      end
      exp_level[i] = lvl[i];
    end
    exp_pend = exp_pend_q | exp_press | exp_long;
  endtask

  task automatic checkOutput();
    chk("level",   level_o,   exp_level);
    chk("press",   press_o,   exp_press);
    chk("release", release_o, exp_rel);
    chk("long",    long_o,    exp_long);
    chk("pend",    pend_o,    exp_pend);
    chk("irq",     {3'b000, irq_o}, {3'b000, exp_irq});
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] en, input logic [3:0] clr);
    asserted   = a;
    raw_in     = a ^ MASK;
    irq_en_i   = en;
    pend_clr_i = clr;
    @(posedge clk);
    #1;
    modelStep();
    checkOutput();
  endtask

  // kind: 0 = press, 1 = release, 2 = long; latency counted in applied cycles.
  task automatic waitEvent(input string tag, input int ch, input int kind, input int lat,
                           input logic [3:0] a, input logic [3:0] en, input logic [3:0] clr);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 60) begin
      applyStimulus(a, en, clr);
      n++;
      case (kind)
        0: seen = press_o[ch];
        1: seen = release_o[ch];
        default: seen = long_o[ch];
      endcase
    end
    chkInt(tag, seen ? n : -1, lat);
  endtask

  initial begin
    int bounce_cnt;
    int long_cnt;
    logic [3:0] a, en, clr;

    rst_n      = 1'b0;
    asserted   = 4'b0000;
    raw_in     = MASK;
    irq_en_i   = 4'b0000;
    pend_clr_i = 4'b0000;
    modelReset();
    #2;
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] reset release idle");
    repeat (100) applyStimulus(4'b0000, 4'b0000, 4'b0000);

    $display("[TB] clean press ch0");
    waitEvent("press0_latency", 0, 0, 10, 4'b0001, 4'b0001, 4'b0000);
    chk("level0_at_press", {3'b000, level_o[0]}, 4'b0001);
    applyStimulus(4'b0001, 4'b0001, 4'b0000);
    chk("irq_after_press0", {3'b000, irq_o}, 4'b0001);

    $display("[TB] bounce ch2");
    bounce_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      a = (k % 2 == 0) ? 4'b0101 : 4'b0001;
      repeat (3) begin
        applyStimulus(a, 4'b0001, 4'b0000);
        if (press_o[2]) bounce_cnt++;
      end
    end
    chkInt("bounce_no_press", bounce_cnt, 0);
    waitEvent("press2_after_bounce", 2, 0, 10, 4'b0101, 4'b0001, 4'b0000);

    $display("[TB] long press ch1");
    waitEvent("press1_latency", 1, 0, 10, 4'b0111, 4'b0001, 4'b0000);
    waitEvent("long1_latency", 1, 2, 40, 4'b0111, 4'b0001, 4'b0000);
    long_cnt = 0;
    repeat (20) begin
      applyStimulus(4'b0111, 4'b0001, 4'b0000);
      if (long_o[1]) long_cnt++;
    end
    waitEvent("release1_latency", 1, 1, 10, 4'b0101, 4'b0001, 4'b0000);
    repeat (10) begin
      applyStimulus(4'b0101, 4'b0001, 4'b0000);
      if (long_o[1]) long_cnt++;
    end
    chkInt("long1_single", long_cnt, 0);

    $display("[TB] clear race ch0");
    waitEvent("release0_latency", 0, 1, 10, 4'b0100, 4'b0001, 4'b0000);
    applyStimulus(4'b0100, 4'b0001, 4'b0001);
    repeat (3) applyStimulus(4'b0100, 4'b0001, 4'b0000);
    chk("pend0_cleared", {3'b000, pend_o[0]}, 4'b0000);
    waitEvent("press0_again", 0, 0, 10, 4'b0101, 4'b0001, 4'b0000);
    applyStimulus(4'b0101, 4'b0001, 4'b0001);
    chk("pend0_set_wins", {3'b000, pend_o[0]}, 4'b0001);
    applyStimulus(4'b0101, 4'b0001, 4'b0001);
    chk("pend0_clear", {3'b000, pend_o[0]}, 4'b0000);
    chk("irq_still_high", {3'b000, irq_o}, 4'b0001);
    applyStimulus(4'b0101, 4'b0001, 4'b0000);
    chk("irq_dropped", {3'b000, irq_o}, 4'b0000);

    $display("[TB] async reset during release check ch3");
    waitEvent("press3_latency", 3, 0, 10, 4'b1101, 4'b0001, 4'b0000);
    repeat (6) applyStimulus(4'b0101, 4'b0001, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    chk("reset_all_level", level_o, 4'b0000);
    applyStimulus(4'b0101, 4'b0001, 4'b0000);
    rst_n = 1'b1;
    waitEvent("press3_after_reset", 3, 0, 10, 4'b1101, 4'b0001, 4'b0000);

    $display("[TB] randomized traffic");
    a   = 4'b1101;
    en  = 4'b0001;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 11) == 0) a[i] = ~a[i];
      end
      if (c % 50 == 0) en = 4'($urandom_range(0, 15));
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      applyStimulus(a, en, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
